// File: rtl/poly_signal_generator.sv
// poly_signal_generator: NUM_VOICES independent tone voices (square, 25 %
// pulse or LFSR noise) programmed through an asynchronous strobe/address/data
// write port, summed by volume and turned into a first-order sigma-delta bit.
module poly_signal_generator #(
   parameter int NUM_VOICES   = 3,
   parameter int PRESCALE     = 50,
   parameter int PERIOD_WIDTH = 10,
   parameter int VOL_WIDTH    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  write_strobe,
   input  logic [3:0]            address,
   input  logic [4:0]            data,
   output logic                  signal_out,
   output logic [NUM_VOICES-1:0] voice_active
);

   localparam int PRE_W = $clog2(PRESCALE);
   localparam int LVL_W = VOL_WIDTH + 2;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [14:0]      LFSR_SEED = 15'h0001;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_SQUARE = 2'd1,
      MODE_PULSE  = 2'd2,
      MODE_NOISE  = 2'd3
   } mode_e;

   logic [1:0]              strobeSync_q;
   logic                    strobeDly_q;
   logic                    writeFire;

   logic [PRE_W-1:0]        preCount_q, preCount_d;
   logic                    tick;

   logic [PERIOD_WIDTH-1:0] period_q [NUM_VOICES];
   logic [PERIOD_WIDTH-1:0] period_d [NUM_VOICES];
   mode_e                   mode_q   [NUM_VOICES];
   mode_e                   mode_d   [NUM_VOICES];
   logic [VOL_WIDTH-1:0]    vol_q    [NUM_VOICES];
   logic [VOL_WIDTH-1:0]    vol_d    [NUM_VOICES];
   logic [PERIOD_WIDTH-1:0] count_q  [NUM_VOICES];
   logic [PERIOD_WIDTH-1:0] count_d  [NUM_VOICES];
   logic [1:0]              phase_q  [NUM_VOICES];
   logic [1:0]              phase_d  [NUM_VOICES];
   logic [14:0]             lfsr_q   [NUM_VOICES];
   logic [14:0]             lfsr_d   [NUM_VOICES];
   logic [NUM_VOICES-1:0]   square_q, square_d;
   logic [NUM_VOICES-1:0]   voiceBit_q, voiceBit_d;

   logic [LVL_W-1:0]        level;
   logic [LVL_W:0]          accSum;
   logic [LVL_W-1:0]        acc_q, acc_d;
   logic                    out_q, out_d;

   // Bring the asynchronous strobe into the clk domain; the delay flop lets a
   // held-high strobe produce exactly one write on its rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobeSync_q <= '0;
         strobeDly_q  <= 1'b0;
      end else begin
         strobeSync_q <= {strobeSync_q[0], write_strobe};
         strobeDly_q  <= strobeSync_q[1];
      end
   end

   assign writeFire = strobeSync_q[1] & ~strobeDly_q;

   // Tone tick: one clk-wide pulse every PRESCALE enabled cycles, count held while ena is low.
   always_comb begin
      tick       = ena && (preCount_q == PRE_LAST);
      preCount_d = preCount_q;
      if (ena) begin
         preCount_d = tick ? '0 : preCount_q + PRE_W'(1);
      end
   end

   // Per-voice next state: a firing write is applied first, so a tick in the
   // same cycle already sees the new period, mode or the phase reset.
   always_comb begin
      square_d   = square_q;
      voiceBit_d = voiceBit_q;
      for (int v = 0; v < NUM_VOICES; v++) begin
         period_d[v] = period_q[v];
         mode_d[v]   = mode_q[v];
         vol_d[v]    = vol_q[v];
         count_d[v]  = count_q[v];
         phase_d[v]  = phase_q[v];
         lfsr_d[v]   = lfsr_q[v];
         if (writeFire && (int'(address[3:2]) == v)) begin
            case (address[1:0])
               2'd0: period_d[v][4:0] = data;
               2'd1: period_d[v][PERIOD_WIDTH-1:5] = data[PERIOD_WIDTH-6:0];
               2'd2: begin
                  vol_d[v]  = VOL_WIDTH'(data[4:2]);
                  mode_d[v] = mode_e'(data[1:0]);
               end
               default: begin
                  count_d[v]    = '0;
                  square_d[v]   = 1'b0;
                  phase_d[v]    = 2'd0;
                  lfsr_d[v]     = LFSR_SEED;
                  voiceBit_d[v] = 1'b0;
               end
            endcase
         end
         if ((mode_d[v] == MODE_OFF) || (period_d[v] == '0)) begin
            count_d[v]    = '0;
            voiceBit_d[v] = 1'b0;
         end else if (tick) begin
            if (count_d[v] >= (period_d[v] - PERIOD_WIDTH'(1))) begin
               count_d[v] = '0;
               case (mode_d[v])
                  MODE_SQUARE: begin
                     square_d[v]   = ~square_d[v];
                     voiceBit_d[v] = square_d[v];
                  end
                  MODE_PULSE: begin
                     phase_d[v]    = phase_d[v] + 2'd1;
                     voiceBit_d[v] = (phase_d[v] == 2'd0);
                  end
                  MODE_NOISE: begin
                     lfsr_d[v]     = {lfsr_d[v][13:0], lfsr_d[v][14] ^ lfsr_d[v][13]};
                     voiceBit_d[v] = lfsr_d[v][14];
                  end
                  default: voiceBit_d[v] = 1'b0;
               endcase
            end else begin
               count_d[v] = count_d[v] + PERIOD_WIDTH'(1);
            end
         end
      end
   end

   // Mixer and sigma-delta: the carry out of the accumulator is the audio bit.
   always_comb begin
      level = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (voiceBit_q[v]) begin
            level = level + LVL_W'(vol_q[v]);
         end
      end
      accSum = {1'b0, acc_q} + {1'b0, level};
      acc_d  = acc_q;
      out_d  = 1'b0;
      if (ena) begin
         acc_d = accSum[LVL_W-1:0];
         out_d = accSum[LVL_W];
      end
   end

   // State registers for prescaler, voices and modulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preCount_q <= '0;
         square_q   <= '0;
         voiceBit_q <= '0;
         acc_q      <= '0;
         out_q      <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            period_q[v] <= '0;
            mode_q[v]   <= MODE_OFF;
            vol_q[v]    <= '0;
            count_q[v]  <= '0;
            phase_q[v]  <= 2'd0;
            lfsr_q[v]   <= LFSR_SEED;
         end
      end else begin
         preCount_q <= preCount_d;
         square_q   <= square_d;
         voiceBit_q <= voiceBit_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         for (int v = 0; v < NUM_VOICES; v++) begin
            period_q[v] <= period_d[v];
            mode_q[v]   <= mode_d[v];
            vol_q[v]    <= vol_d[v];
            count_q[v]  <= count_d[v];
            phase_q[v]  <= phase_d[v];
            lfsr_q[v]   <= lfsr_d[v];
         end
      end
   end

   assign signal_out   = out_q;
   assign voice_active = voiceBit_q;

endmodule

// File: tb/tb_poly_signal_generator.sv
// Testbench for poly_signal_generator: a behavioural model advanced on every
// clk edge pushes the expected outputs into a queue, and a monitor on the
// falling edge pops and compares them against the design.
module tb_poly_signal_generator;

   localparam int NV      = 3;
   localparam int PRE     = 4;
   localparam int PW      = 10;
   localparam int VW      = 3;
   localparam int LVL_MOD = 1 << (VW + 2);

   logic          clk          = 1'b0;
   logic          rst_n        = 1'b1;
   logic          ena          = 1'b0;
   logic          write_strobe = 1'b0;
   logic [3:0]    address      = '0;
   logic [4:0]    data         = '0;
   logic          signal_out;
   logic [NV-1:0] voice_active;

   poly_signal_generator #(
      .NUM_VOICES  (NV),
      .PRESCALE    (PRE),
      .PERIOD_WIDTH(PW),
      .VOL_WIDTH   (VW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .write_strobe(write_strobe),
      .address     (address),
      .data        (data),
      .signal_out  (signal_out),
      .voice_active(voice_active)
   );

   // Free-running 10 time-unit clock.
   always #5 clk = ~clk;

   typedef struct {
      int due;
      int voice;
      int regSel;
      int value;
   } write_t;

   typedef struct {
      logic [NV-1:0] bits;
      logic          out;
   } expect_t;

   write_t  pendingQ[$];
   expect_t expQ[$];
   expect_t monExp;

   int vectors     = 0;
   int miscompares = 0;
   int edgeNo      = 0;

   int mPeriod[NV];
   int mMode[NV];
   int mVol[NV];
   int mSince[NV];
   int mSquare[NV];
   int mPulse[NV];
   int mNoise[NV];
   int mBit[NV];
   int mPre;
   int mAcc;
   int mOut;

   function automatic void checkOutput(input string name, input logic [31:0] actual,
                                       input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endfunction

   function automatic void modelReset();
      for (int v = 0; v < NV; v++) begin
         mPeriod[v] = 0;
         mMode[v]   = 0;
         mVol[v]    = 0;
         mSince[v]  = 0;
         mSquare[v] = 0;
         mPulse[v]  = 0;
         mNoise[v]  = 1;
         mBit[v]    = 0;
      end
      mPre = 0;
      mAcc = 0;
      mOut = 0;
      pendingQ.delete();
      expQ.delete();
   endfunction

   function automatic void applyWrite(input write_t w);
      int v;
      v = w.voice;
      if (v >= NV) return;
      case (w.regSel)
         0: mPeriod[v] = (mPeriod[v] / 32) * 32 + w.value;
         1: mPeriod[v] = (mPeriod[v] % 32) + (w.value % (1 << (PW - 5))) * 32;
         2: begin
            mVol[v]  = w.value / 4;
            mMode[v] = w.value % 4;
         end
         default: begin
            mSince[v]  = 0;
            mSquare[v] = 0;
            mPulse[v]  = 0;
            mNoise[v]  = 1;
            mBit[v]    = 0;
         end
      endcase
   endfunction

   function automatic void voiceEvent(input int v);
      int fb;
      case (mMode[v])
         1: begin
            mSquare[v] = 1 - mSquare[v];
            mBit[v]    = mSquare[v];
         end
         2: begin
            mPulse[v] = (mPulse[v] + 1) % 4;
            mBit[v]   = (mPulse[v] == 0) ? 1 : 0;
         end
         default: begin
            fb        = ((mNoise[v] / 16384) + (mNoise[v] / 8192)) % 2;
            mNoise[v] = (mNoise[v] * 2 + fb) % 32768;
            mBit[v]   = (mNoise[v] >= 16384) ? 1 : 0;
         end
      endcase
   endfunction

   function automatic void modelStep();
      int      level;
      bit      tickNow;
      write_t  w;
      expect_t e;
      edgeNo++;
      level = 0;
      for (int v = 0; v < NV; v++) level += (mBit[v] != 0) ? mVol[v] : 0;
      tickNow = (ena === 1'b1) && (mPre == PRE - 1);
      if (ena === 1'b1) begin
         mPre = (mPre + 1) % PRE;
         mAcc = mAcc + level;
         mOut = (mAcc >= LVL_MOD) ? 1 : 0;
         mAcc = mAcc % LVL_MOD;
      end else begin
         mOut = 0;
      end
      while (pendingQ.size() > 0 && pendingQ[0].due <= edgeNo) begin
         w = pendingQ.pop_front();
         applyWrite(w);
      end
      for (int v = 0; v < NV; v++) begin
         if (mMode[v] == 0 || mPeriod[v] == 0) begin
            mSince[v] = 0;
            mBit[v]   = 0;
         end else if (tickNow) begin
            if (mSince[v] >= mPeriod[v] - 1) begin
               mSince[v] = 0;
               voiceEvent(v);
            end else begin
               mSince[v]++;
            end
         end
      end
      for (int v = 0; v < NV; v++) e.bits[v] = (mBit[v] != 0);
      e.out = (mOut != 0);
      expQ.push_back(e);
   endfunction

   // Reference model: reset with the design, otherwise advance one clk edge and queue the expectation.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) modelReset();
      else        modelStep();
   end

   // Monitor: every enabled-reset cycle presents a new output pair to compare.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && expQ.size() > 0) begin
         monExp = expQ.pop_front();
         checkOutput("voice_active", voice_active, monExp.bits);
         checkOutput("signal_out", signal_out, monExp.out);
      end
   end

   task automatic waitCycle();
      @(negedge clk);
      #1;
   endtask

   // One register write: strobe rises now, the model applies it three edges later.
   task automatic applyStimulus(input logic [3:0] a, input logic [4:0] d, input int highCycles);
      write_t w;
      address      = a;
      data         = d;
      w.due        = edgeNo + 3;
      w.voice      = a[3:2];
      w.regSel     = a[1:0];
      w.value      = d;
      pendingQ.push_back(w);
      write_strobe = 1'b1;
      repeat (highCycles) waitCycle();
      write_strobe = 1'b0;
      repeat (3) waitCycle();
   endtask

   task automatic measureToggle(input int idx, input int expected);
      logic prev;
      int   n;
      bit   seen;
      prev = voice_active[idx];
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         waitCycle();
         if (voice_active[idx] !== prev) seen = 1'b1;
      end
      checkOutput("toggle seen", 32'(seen), 1);
      prev = voice_active[idx];
      seen = 1'b0;
      n    = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         waitCycle();
         n++;
         if (voice_active[idx] !== prev) seen = 1'b1;
      end
      checkOutput("square half period", seen ? n : -1, expected);
   endtask

   initial begin
      logic [3:0] ra;
      logic [4:0] rd;
      modelReset();
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ena          = 1'($urandom);
         address      = 4'($urandom);
         data         = 5'($urandom);
         write_strobe = 1'($urandom);
         #3;
         checkOutput("reset signal_out", signal_out, 0);
         checkOutput("reset voice_active", voice_active, 0);
         waitCycle();
      end
      write_strobe = 1'b0;
      ena          = 1'b1;
      repeat (2) waitCycle();
      rst_n = 1'b1;
      $display("[TB] idle after reset");
      repeat (1000) waitCycle();

      $display("[TB] square voice0");
      applyStimulus(4'b0000, 5'd3, 4);
      applyStimulus(4'b0001, 5'd0, 4);
      applyStimulus(4'b0010, 5'b11101, 4);
      applyStimulus(4'b0011, 5'd0, 4);
      measureToggle(0, 12);
      measureToggle(0, 12);

      $display("[TB] noise voice1");
      applyStimulus(4'b0100, 5'd1, 4);
      applyStimulus(4'b0101, 5'd0, 4);
      applyStimulus(4'b0110, 5'b10111, 4);
      applyStimulus(4'b0111, 5'd0, 4);
      repeat (80) waitCycle();

      $display("[TB] three voices in phase");
      ena = 1'b0;
      applyStimulus(4'b0000, 5'd2, 4);
      applyStimulus(4'b0100, 5'd2, 4);
      applyStimulus(4'b0110, 5'b11101, 4);
      applyStimulus(4'b1000, 5'd2, 4);
      applyStimulus(4'b1001, 5'd0, 4);
      applyStimulus(4'b1010, 5'b11101, 4);
      applyStimulus(4'b0011, 5'd0, 4);
      applyStimulus(4'b0111, 5'd0, 4);
      applyStimulus(4'b1011, 5'd0, 4);
      ena = 1'b1;
      repeat (200) waitCycle();

      $display("[TB] period shrink wrap");
      applyStimulus(4'b0000, 5'd10, 4);
      applyStimulus(4'b0011, 5'd0, 4);
      repeat (20) waitCycle();
      applyStimulus(4'b0000, 5'd2, 4);
      repeat (100) waitCycle();

      $display("[TB] ignored voice and long strobe");
      applyStimulus(4'b1100, 5'($urandom), 4);
      applyStimulus(4'b1110, 5'b11111, 4);
      repeat (50) waitCycle();
      applyStimulus(4'b1011, 5'd0, 100);
      repeat (50) waitCycle();

      $display("[TB] ena freeze");
      repeat (30) waitCycle();
      ena = 1'b0;
      repeat (37) waitCycle();
      ena = 1'b1;
      repeat (60) waitCycle();

      $display("[TB] random writes");
      for (int i = 0; i < 40; i++) begin
         ra = 4'($urandom);
         rd = 5'($urandom);
         if (ra[1:0] == 2'd1) rd = 5'($urandom_range(0, 1));
         applyStimulus(ra, rd, $urandom_range(4, 8));
         if ($urandom_range(0, 3) == 0) ena = ~ena;
         repeat ($urandom_range(0, 20)) waitCycle();
      end
      ena = 1'b1;
      repeat (200) waitCycle();

      $display("[TB] reset mid-operation");
      address      = 4'b0010;
      data         = 5'b11101;
      write_strobe = 1'b1;
      waitCycle();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset signal_out", signal_out, 0);
      checkOutput("midreset voice_active", voice_active, 0);
      write_strobe = 1'b0;
      repeat (2) waitCycle();
      rst_n = 1'b1;
      repeat (300) waitCycle();
      applyStimulus(4'b0000, 5'd1, 4);
      applyStimulus(4'b0010, 5'b01101, 4);
      repeat (100) waitCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
